regfile_access_arbiter: RTL

Round-robin arbiter that shares one register file among `NUM_REQ` requesters. Each requester issues single-word read or write transactions over a valid/ready handshake. The arbiter grants at most one transaction per cycle and drives the register file's write and read ports. It registers the read data and returns it to the granted requester one cycle later. It sits between the requesting datapath blocks and the `register_file` instance, whose parameters it mirrors.

---
 rtl/regfile_access_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one register file among NUM_REQ requesters.
// One access per cycle; read data is registered and returned next cycle.
module regfile_access_arbiter #(
  parameter int word_width = 32,
  parameter int length = 128,
  parameter int NUM_REQ = 4,
  localparam int AW = $clog2(length),
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*AW-1:0]         req_addr,
  input  logic [NUM_REQ*word_width-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [word_width-1:0]         rsp_rdata,
  output logic                          rf_write,
  output logic [AW-1:0]                 rf_write_addres,
  output logic [word_width-1:0]         rf_in_data,
  output logic                          rf_read,
  output logic [AW-1:0]                 rf_read_addres,
  input  logic [word_width-1:0]         rf_out_data
);

  logic [IW-1:0]         last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [word_width-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  gnt_found;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         cand;
  logic                  grant;
  logic                  gnt_write;
  logic [AW-1:0]         gnt_addr;
  logic [word_width-1:0] gnt_wdata;

  // Search valid requesters starting one past the last winner, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant     = gnt_found & enable & ~reset;
  assign gnt_write = req_write[gnt_idx];
  assign gnt_addr  = req_addr[gnt_idx*AW +: AW];
  assign gnt_wdata = req_wdata[gnt_idx*word_width +: word_width];

  // Drive the one-hot grant and the register file ports.
  always_comb begin
    req_ready       = '0;
    rf_write        = 1'b0;
    rf_write_addres = '0;
    rf_in_data      = '0;
    rf_read         = 1'b0;
    rf_read_addres  = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
      if (gnt_write) begin
        rf_write        = 1'b1;
        rf_write_addres = gnt_addr;
        rf_in_data      = gnt_wdata;
      end else begin
        rf_read        = 1'b1;
        rf_read_addres = gnt_addr;
      end
    end
  end

  // Next pointer and read response; a granted read captures data now.
  always_comb begin
    last_grant_d = last_grant_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    if (grant) begin
      last_grant_d = gnt_idx;
      if (!gnt_write) begin
        rsp_valid_d = req_ready;
        rsp_rdata_d = rf_out_data;
      end
    end
  end

  // State registers; reset points the search so requester 0 goes first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= IW'(NUM_REQ - 1);
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
